// File: rtl/lsu_ctrl_pkg.sv
// lsu_ctrl_pkg -- shared definitions for the load/store unit controller.
//
// Contents:
//   state_t     FSM state encoding (IDLE, REQ, DONE)
//   F3_*        funct3 access size/sign codes
//   size_t      access width class derived from funct3
//   acc_size    funct3 -> size class (unknown codes are word accesses)
//   store_we    byte-lane write enables for a store
//   store_wdata lane-replicated store data
//   misaligned  alignment test used when LSU_MISALIGN_CHK_EN is defined
package lsu_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } size_t;

   // Any funct3 that is not a byte or halfword code is handled as a word.
   function automatic size_t acc_size(input logic [2:0] f3);
      size_t sz;
      case (f3)
         F3_B, F3_BU: sz = SZ_BYTE;
         F3_H, F3_HU: sz = SZ_HALF;
         default:     sz = SZ_WORD;
      endcase
      return sz;
   endfunction

   function automatic logic [3:0] store_we(input size_t sz, input logic [1:0] off);
      logic [3:0] we;
      case (sz)
         SZ_BYTE: we = 4'b0001 << off;
         SZ_HALF: we = off[1] ? 4'b1100 : 4'b0011;
         default: we = 4'b1111;
      endcase
      return we;
   endfunction

   // Data is replicated on every lane; the enables pick the lanes written.
   function automatic logic [31:0] store_wdata(input size_t sz, input logic [31:0] rs2);
      logic [31:0] wd;
      case (sz)
         SZ_BYTE: wd = {4{rs2[7:0]}};
         SZ_HALF: wd = {2{rs2[15:0]}};
         default: wd = rs2;
      endcase
      return wd;
   endfunction

   function automatic logic misaligned(input size_t sz, input logic [1:0] off);
      logic bad;
      case (sz)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = off[0];
         default: bad = (off != 2'b00);
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if -- data-memory bus between the LSU controller and memory.
//
// Signals:
//   dm_req    request active (LSU -> memory)
//   dm_we     byte write enables, bit i = lane i, 0000 for reads
//   dm_addr   word address
//   dm_wdata  lane-replicated store data
//   dm_rdata  read word (memory -> LSU)
//   dm_ready  memory completes the request this cycle (memory -> LSU)
//
// Handshake: a transfer completes on a rising clock edge where dm_req and
// dm_ready are both high. While dm_req is high and dm_ready is low, the LSU
// holds dm_addr, dm_we and dm_wdata stable. dm_rdata is sampled only on the
// completing edge. dm_ready is ignored while dm_req is low. The LSU may drop
// dm_req without completion only on its own wait timeout or on reset.
interface lsu_ctrl_if #(
   parameter int ADDR_W = 14
);
   logic              dm_req;
   logic [3:0]        dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [31:0]       dm_wdata;
   logic [31:0]       dm_rdata;
   logic              dm_ready;

   modport master (
      output dm_req, dm_we, dm_addr, dm_wdata,
      input  dm_rdata, dm_ready
   );

   modport slave (
      input  dm_req, dm_we, dm_addr, dm_wdata,
      output dm_rdata, dm_ready
   );
endinterface

// File: rtl/lsu_load_align.sv
// lsu_load_align -- combinational load lane selection and extension.
//
// Ports:
//   funct3   in   3   access size/sign code
//   off      in   2   byte offset within the word
//   word     in  32   word read from memory
//   ld_data  out 32   selected, sign- or zero-extended load value
module lsu_load_align
   import lsu_ctrl_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  off,
   input  logic [31:0] word,
   output logic [31:0] ld_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word[7:0];
      case (off)
         2'd0:    byte_sel = word[7:0];
         2'd1:    byte_sel = word[15:8];
         2'd2:    byte_sel = word[23:16];
         default: byte_sel = word[31:24];
      endcase
   end

   assign half_sel = off[1] ? word[31:16] : word[15:0];

   always_comb begin
      ld_data = word;
      case (funct3)
         F3_B:    ld_data = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   ld_data = {24'h0, byte_sel};
         F3_H:    ld_data = {{16{half_sel[15]}}, half_sel};
         F3_HU:   ld_data = {16'h0, half_sel};
         default: ld_data = word;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl -- load/store unit controller between EXE and data memory.
//
// Parameters:
//   ADDR_W   data-memory word-address width
//   TIMEOUT  maximum REQ cycles spent waiting for dm_ready
//
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   valid_EXE       EXE slot holds a real instruction
//   MemRead_EXE     load
//   MemWrite_EXE    store (wins when both are set)
//   funct3_EXE      access size/sign
//   addr_EXE        byte address
//   rs2_data_EXE    store data
//   dm              lsu_ctrl_if master: dm_req/dm_we/dm_addr/dm_wdata out,
//                   dm_rdata/dm_ready in
//   stall           holds upstream stages while an access is accepted/in REQ
//   ld_data         extended load result
//   ld_valid        one-cycle pulse when ld_data is valid
//   err             one-cycle pulse on timeout (or misalignment, see below)
//   state_dbg       current FSM state
//
// Build option: define LSU_MISALIGN_CHK_EN to reject misaligned halfword and
// word accesses (no dm_req, err pulse one cycle after accept). Without it,
// no alignment check is made and lanes follow the low address bits.
module lsu_ctrl
   import lsu_ctrl_pkg::*;
#(
   parameter int ADDR_W  = 14,
   parameter int TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_EXE,
   input  logic        MemRead_EXE,
   input  logic        MemWrite_EXE,
   input  logic [2:0]  funct3_EXE,
   input  logic [31:0] addr_EXE,
   input  logic [31:0] rs2_data_EXE,
   lsu_ctrl_if.master  dm,
   output logic        stall,
   output logic [31:0] ld_data,
   output logic        ld_valid,
   output logic        err,
   output state_t      state_dbg
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t            state;
   state_t            state_next;
   logic [CNT_W-1:0]  cnt;

   // Values latched at accept; they drive the bus for the whole REQ phase.
   logic [ADDR_W-1:0] addr_q;
   logic [1:0]        off_q;
   logic [2:0]        f3_q;
   logic              store_q;
   logic [3:0]        we_q;
   logic [31:0]       wdata_q;
   logic [31:0]       ld_data_q;
   logic              err_q;

   logic              accept;
   logic              misalign_in;
   logic              err_set;
   logic              req;
   logic [3:0]        we_out;
   size_t             sz_in;
   logic [1:0]        off_in;
   logic [31:0]       aligned;

   // Address bits above the memory window and the lane offset bits are not
   // part of the word address.
   logic              addr_hi_unused;
   assign addr_hi_unused = ^addr_EXE[31:ADDR_W+2];

   assign accept = valid_EXE & (MemRead_EXE | MemWrite_EXE);
   assign sz_in  = acc_size(funct3_EXE);
   assign off_in = addr_EXE[1:0];

`ifdef LSU_MISALIGN_CHK_EN
   assign misalign_in = misaligned(sz_in, off_in);
`else
   assign misalign_in = 1'b0;
`endif

   lsu_load_align u_load_align (
      .funct3  (f3_q),
      .off     (off_q),
      .word    (dm.dm_rdata),
      .ld_data (aligned)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and output decode.
   always_comb begin
      state_next = state;
      stall      = 1'b0;
      req        = 1'b0;
      we_out     = 4'b0000;
      ld_valid   = 1'b0;
      err_set    = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               stall = 1'b1;
               if (misalign_in) begin
                  // Rejected without touching memory; err shows next cycle.
                  err_set = 1'b1;
               end else begin
                  state_next = REQ;
               end
            end
         end
         REQ: begin
            stall  = 1'b1;
            req    = 1'b1;
            we_out = we_q;
            if (dm.dm_ready) begin
               state_next = DONE;
            end else if (cnt == CNT_LAST) begin
               // This is the TIMEOUT-th cycle without dm_ready: give up.
               state_next = IDLE;
               err_set    = 1'b1;
            end
         end
         DONE: begin
            ld_valid   = ~store_q;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         addr_q    <= '0;
         off_q     <= 2'b00;
         f3_q      <= 3'b000;
         store_q   <= 1'b0;
         we_q      <= 4'b0000;
         wdata_q   <= 32'h0;
         ld_data_q <= 32'h0;
         err_q     <= 1'b0;
      end else begin
         err_q <= err_set;

         if (state == IDLE && accept) begin
            addr_q  <= addr_EXE[ADDR_W+1:2];
            off_q   <= off_in;
            f3_q    <= funct3_EXE;
            store_q <= MemWrite_EXE;
            we_q    <= MemWrite_EXE ? store_we(sz_in, off_in) : 4'b0000;
            wdata_q <= store_wdata(sz_in, rs2_data_EXE);
         end

         // Held at zero outside REQ, so every REQ phase starts counting at 0.
         if (state != REQ) begin
            cnt <= '0;
         end else if (!dm.dm_ready) begin
            cnt <= cnt + 1'b1;
         end

         if (state == REQ && dm.dm_ready && !store_q) begin
            ld_data_q <= aligned;
         end
      end
   end

   assign dm.dm_req   = req;
   assign dm.dm_we    = we_out;
   assign dm.dm_addr  = addr_q;
   assign dm.dm_wdata = wdata_q;
   assign ld_data     = ld_data_q;
   assign err         = err_q;
   assign state_dbg   = state;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl -- self-checking bench for lsu_ctrl.
// Each access is planned up front (direction, size, address, memory latency);
// the planner turns it into one expected output record per clock cycle,
// derived from the access rules with plain arithmetic, and a compare process
// checks the DUT against those records on the falling edge.
module tb_lsu_ctrl;
   import lsu_ctrl_pkg::*;

   localparam int ADDR_W  = 14;
   localparam int TIMEOUT = 15;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_EXE, MemRead_EXE, MemWrite_EXE;
   logic [2:0]  funct3_EXE;
   logic [31:0] addr_EXE, rs2_data_EXE;
   logic        stall, ld_valid, err;
   logic [31:0] ld_data;
   state_t      state_dbg;

   lsu_ctrl_if #(.ADDR_W(ADDR_W)) dm_bus ();

   lsu_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .rst          (rst),
      .valid_EXE    (valid_EXE),
      .MemRead_EXE  (MemRead_EXE),
      .MemWrite_EXE (MemWrite_EXE),
      .funct3_EXE   (funct3_EXE),
      .addr_EXE     (addr_EXE),
      .rs2_data_EXE (rs2_data_EXE),
      .dm           (dm_bus),
      .stall        (stall),
      .ld_data      (ld_data),
      .ld_valid     (ld_valid),
      .err          (err),
      .state_dbg    (state_dbg)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic              stall;
      logic              req;
      logic [3:0]        we;
      logic [ADDR_W-1:0] addr;
      logic              wd;
      logic [31:0]       wdata;
      logic              ldv;
      logic [31:0]       ldd;
      logic              err;
      logic              zero;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // Observations of the DUT for the directed literal checks.
   logic [3:0]        obs_we;
   logic [ADDR_W-1:0] obs_addr;
   logic [31:0]       obs_wdata, obs_ldd;
   int                n_stall, n_req, n_ldv, n_err;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got=%h expected=%h at t=%0t", name, got, want, $time);
      end
   endtask

   initial begin : compare
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("stall",    32'(stall),          32'(e.stall));
            chk("dm_req",   32'(dm_bus.dm_req),  32'(e.req));
            chk("dm_we",    32'(dm_bus.dm_we),   32'(e.we));
            chk("ld_valid", 32'(ld_valid),       32'(e.ldv));
            chk("err",      32'(err),            32'(e.err));
            if (e.req) chk("dm_addr", 32'(dm_bus.dm_addr), 32'(e.addr));
            if (e.wd)  chk("dm_wdata", dm_bus.dm_wdata, e.wdata);
            if (e.ldv) chk("ld_data", ld_data, e.ldd);
            if (e.zero) begin
               chk("rst_dm_addr",  32'(dm_bus.dm_addr), 32'h0);
               chk("rst_dm_wdata", dm_bus.dm_wdata,     32'h0);
               chk("rst_ld_data",  ld_data,             32'h0);
            end
            if (stall) n_stall++;
            if (dm_bus.dm_req) begin
               n_req++;
               obs_we    = dm_bus.dm_we;
               obs_addr  = dm_bus.dm_addr;
               obs_wdata = dm_bus.dm_wdata;
            end
            if (ld_valid) begin
               n_ldv++;
               obs_ldd = ld_data;
            end
            if (err) n_err++;
         end
      end
   end

   // ---------------- reference model ----------------
   function automatic int m_size(input logic [2:0] f3);
      if (f3[1:0] == 2'b00) return 1;
      if (f3[1:0] == 2'b01) return 2;
      return 4;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] off,
                                          input logic [31:0] w);
      logic [31:0] v;
      int n;
      n = m_size(f3);
      v = w;
      if (n == 1) begin
         v = (w >> (8 * off)) & 32'hFF;
         if (!f3[2] && v[7]) v = v | 32'hFFFFFF00;
      end else if (n == 2) begin
         v = (w >> (16 * off[1])) & 32'hFFFF;
         if (!f3[2] && v[15]) v = v | 32'hFFFF0000;
      end
      return v;
   endfunction

   function automatic logic [3:0] m_we(input logic [2:0] f3, input logic [1:0] off);
      int n;
      n = m_size(f3);
      if (n == 1) return 4'b0001 << off;
      if (n == 2) return off[1] ? 4'b1100 : 4'b0011;
      return 4'b1111;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] rs2);
      int n;
      n = m_size(f3);
      if (n == 1) return {4{rs2[7:0]}};
      if (n == 2) return {2{rs2[15:0]}};
      return rs2;
   endfunction

   function automatic bit m_mis(input logic [2:0] f3, input logic [1:0] off);
`ifdef LSU_MISALIGN_CHK_EN
      int n;
      n = m_size(f3);
      return (n == 2 && off[0]) || (n == 4 && off != 2'b00);
`else
      return (f3 == 3'b111) && (off == 2'b11) && 1'b0;
`endif
   endfunction

   function automatic exp_t blank();
      exp_t e;
      e = '0;
      return e;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_obs();
      obs_we = '0; obs_addr = '0; obs_wdata = '0; obs_ldd = '0;
      n_stall = 0; n_req = 0; n_ldv = 0; n_err = 0;
   endtask

   // Random EXE inputs that must be ignored (DUT busy).
   task automatic junk_exe();
      valid_EXE    = 1'($urandom_range(0, 1));
      MemRead_EXE  = 1'($urandom_range(0, 1));
      MemWrite_EXE = 1'($urandom_range(0, 1));
      funct3_EXE   = 3'($urandom_range(0, 7));
      addr_EXE     = $urandom();
      rs2_data_EXE = $urandom();
   endtask

   // Random EXE inputs that are not an accept.
   task automatic idle_exe();
      junk_exe();
      if ($urandom_range(0, 1) == 1) begin
         valid_EXE = 1'b0;
      end else begin
         MemRead_EXE  = 1'b0;
         MemWrite_EXE = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         idle_exe();
         dm_bus.dm_ready = 1'($urandom_range(0, 1));
         dm_bus.dm_rdata = $urandom();
         exp_q.push_back(blank());
         tick();
      end
   endtask

   // One access; memory answers after wait_n REQ cycles (>= TIMEOUT: never).
   task automatic access(input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] rs2,
                         input logic [31:0] rdata, input int wait_n);
      exp_t e;
      logic [1:0] off;
      off = a[1:0];
      valid_EXE = 1'b1; MemRead_EXE = rd; MemWrite_EXE = wr;
      funct3_EXE = f3; addr_EXE = a; rs2_data_EXE = rs2;
      dm_bus.dm_ready = 1'b0;
      dm_bus.dm_rdata = $urandom();
      e = blank(); e.stall = 1'b1;
      exp_q.push_back(e);
      tick();
      if (m_mis(f3, off)) begin
         idle_exe();
         e = blank(); e.err = 1'b1;
         exp_q.push_back(e);
         tick();
         return;
      end
      for (int k = 0; k < TIMEOUT; k++) begin
         junk_exe();
         dm_bus.dm_ready = (k == wait_n);
         dm_bus.dm_rdata = (k == wait_n) ? rdata : $urandom();
         e = blank();
         e.stall = 1'b1; e.req = 1'b1;
         e.we    = wr ? m_we(f3, off) : 4'b0000;
         e.addr  = a[ADDR_W+1:2];
         e.wd    = wr;
         e.wdata = m_wdata(f3, rs2);
         exp_q.push_back(e);
         tick();
         if (k == wait_n) begin
            junk_exe();
            dm_bus.dm_ready = 1'b0;
            e = blank();
            e.ldv = !wr;
            e.ldd = m_load(f3, off, rdata);
            exp_q.push_back(e);
            tick();
            return;
         end
      end
      idle_exe();
      dm_bus.dm_ready = 1'b0;
      e = blank(); e.err = 1'b1;
      exp_q.push_back(e);
      tick();
   endtask

   task automatic reset_mid_req();
      exp_t e;
      logic [31:0] a;
      a = $urandom() & 32'hFFFF_FFFC;
      valid_EXE = 1'b1; MemRead_EXE = 1'b1; MemWrite_EXE = 1'b0;
      funct3_EXE = F3_W; addr_EXE = a; rs2_data_EXE = $urandom();
      dm_bus.dm_ready = 1'b0;
      e = blank(); e.stall = 1'b1;
      exp_q.push_back(e);
      tick();
      e = blank(); e.stall = 1'b1; e.req = 1'b1; e.addr = a[ADDR_W+1:2];
      junk_exe();
      exp_q.push_back(e);
      tick();
      rst = 1'b1;
      valid_EXE = 1'b0;
      exp_q.push_back(e);
      tick();
      rst = 1'b0;
      idle_exe();
      e = blank(); e.zero = 1'b1;
      exp_q.push_back(e);
      tick();
   endtask

   // ---------------- main stimulus ----------------
   initial begin : driver
      exp_t e;
      int op, w;
      logic [2:0] f3;
      rst = 1'b1;
      valid_EXE = 1'b0; MemRead_EXE = 1'b0; MemWrite_EXE = 1'b0;
      funct3_EXE = 3'b000; addr_EXE = 32'h0; rs2_data_EXE = 32'h0;
      dm_bus.dm_ready = 1'b0; dm_bus.dm_rdata = 32'h0;
      clr_obs();
      tick();
      e = blank(); e.zero = 1'b1;
      exp_q.push_back(e);
      tick();
      rst = 1'b0;
      chk("reset_state", 32'(state_dbg), 32'(IDLE));
      idle(2);

      // SB to the top lane.
      clr_obs();
      access(1'b0, 1'b1, F3_B, 32'h0000_1003, 32'h0000_00AB, 32'h0, 0);
      chk("sb_we",    32'(obs_we),   32'h8);
      chk("sb_addr",  32'(obs_addr), 32'h400);
      chk("sb_wdata", obs_wdata,     32'hABAB_ABAB);
      chk("sb_stall_cycles", 32'(n_stall), 32'd2);
      idle(1);

      // LB / LBU lane 1.
      clr_obs();
      access(1'b1, 1'b0, F3_B, 32'h0000_0001, 32'h0, 32'h0000_F100, 0);
      chk("lb_data",  obs_ldd, 32'hFFFF_FFF1);
      chk("lb_pulses", 32'(n_ldv), 32'd1);
      clr_obs();
      access(1'b1, 1'b0, F3_BU, 32'h0000_0001, 32'h0, 32'h0000_F100, 1);
      chk("lbu_data", obs_ldd, 32'h0000_00F1);
      chk("lbu_pulses", 32'(n_ldv), 32'd1);

      // LHU / LH upper half.
      clr_obs();
      access(1'b1, 1'b0, F3_HU, 32'h0000_0002, 32'h0, 32'h8001_1234, 2);
      chk("lhu_data", obs_ldd, 32'h0000_8001);
      chk("lhu_stall_cycles", 32'(n_stall), 32'd4);
      clr_obs();
      access(1'b1, 1'b0, F3_H, 32'h0000_0002, 32'h0, 32'h8001_1234, 0);
      chk("lh_data", obs_ldd, 32'hFFFF_8001);

      // SH upper half.
      clr_obs();
      access(1'b0, 1'b1, F3_H, 32'h0000_0012, 32'h1234_ABCD, 32'h0, 0);
      chk("sh_we",    32'(obs_we), 32'hC);
      chk("sh_wdata", obs_wdata,   32'hABCD_ABCD);

      // Read and write together is a store.
      clr_obs();
      access(1'b1, 1'b1, F3_W, 32'h0000_0020, 32'hDEAD_BEEF, 32'h0, 0);
      chk("rw_we", 32'(obs_we), 32'hF);
      chk("rw_no_ld_valid", 32'(n_ldv), 32'd0);

      // Timeout.
      clr_obs();
      access(1'b1, 1'b0, F3_W, 32'h0000_0100, 32'h0, 32'h0, 100);
      chk("to_req_cycles", 32'(n_req), 32'd15);
      chk("to_err_pulses", 32'(n_err), 32'd1);
      chk("to_no_ld_valid", 32'(n_ldv), 32'd0);
      chk("to_state", 32'(state_dbg), 32'(IDLE));

      // Ready on the last allowed cycle still completes.
      clr_obs();
      access(1'b1, 1'b0, F3_W, 32'h0000_0104, 32'h0, 32'h5A5A_1234, TIMEOUT - 1);
      chk("last_ready_ld", obs_ldd, 32'h5A5A_1234);
      chk("last_ready_no_err", 32'(n_err), 32'd0);

      // Misaligned word store.
      clr_obs();
      access(1'b0, 1'b1, F3_W, 32'h0000_0002, 32'h1111_2222, 32'h0, 0);
`ifdef LSU_MISALIGN_CHK_EN
      chk("sw_mis_no_req", 32'(n_req), 32'd0);
      chk("sw_mis_err",    32'(n_err), 32'd1);
`else
      chk("sw_mis_we",     32'(obs_we), 32'hF);
      chk("sw_mis_no_err", 32'(n_err), 32'd0);
`endif

      // Reset while waiting in REQ.
      clr_obs();
      reset_mid_req();
      chk("rst_no_ld_valid", 32'(n_ldv), 32'd0);
      chk("rst_no_err",      32'(n_err), 32'd0);
      chk("rst_state",       32'(state_dbg), 32'(IDLE));

      // Randomized traffic.
      for (int i = 0; i < 250; i++) begin
         op = $urandom_range(0, 2);
         f3 = (op == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
         w  = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 4);
         access(op != 1, op != 0, f3, $urandom(), $urandom(), $urandom(), w);
         idle($urandom_range(0, 2));
      end

      idle(2);
      @(negedge clk);
      #1;
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 14, data-memory word-address width; TIMEOUT, default 15, maximum wait cycles for dm_ready.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_EXE  in  1  EXE result is a real instruction.
- MemRead_EXE  in  1  load.
- MemWrite_EXE  in  1  store.
- funct3_EXE  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
- addr_EXE  in  32  byte address from ALU.
- rs2_data_EXE  in  32  store data.
- dm_req  out  1  memory request.
- dm_we  out  4  byte write enables, bit i = byte lane i; 0000 for reads.
- dm_addr  out  ADDR_W  word address, addr[ADDR_W+1:2].
- dm_wdata  out  32  lane-replicated store data.
- dm_rdata  in  32  read word.
- dm_ready  in  1  memory completes the request this cycle.
- stall  out  1  freezes upstream stages.
- ld_data  out  32  extended load result.
- ld_valid  out  1  one-cycle pulse when ld_data is valid.
- err  out  1  one-cycle pulse on timeout or misalignment.

Function
REQ-003 The FSM SHALL have three states: IDLE, REQ, DONE.
REQ-004 In IDLE, a cycle with valid_EXE & (MemRead_EXE | MemWrite_EXE) SHALL latch addr, funct3, store data and direction, and move to REQ next cycle.
REQ-005 stall SHALL be high combinationally in that IDLE accept cycle and throughout REQ, and SHALL be low in DONE and in idle cycles.
REQ-006 In REQ, dm_req SHALL be 1; dm_addr, dm_we and dm_wdata SHALL come from the latched values and stay stable until dm_ready.
REQ-007 REQ with dm_ready=1 SHALL go to DONE.
- For loads: capture dm_rdata, set ld_data, pulse ld_valid in DONE.
- DONE SHALL return to IDLE after one cycle.
REQ-008 A wait counter SHALL clear on entry to REQ and increment each REQ cycle without dm_ready.
- On reaching TIMEOUT: drop dm_req, pulse err, return to IDLE; no ld_valid.
REQ-009 Store enables, with off = addr[1:0]:
- SB: we = 1<<off; wdata = {4{rs2[7:0]}}.
- SH: we = off[1] ? 1100 : 0011; wdata = {2{rs2[15:0]}}.
- SW: we = 1111; wdata = rs2.
REQ-010 Load data:
- LB/LBU: select byte lane off; LB sign-extends, LBU zero-extends.
- LH/LHU: select halfword off[1]; LH sign-extends, LHU zero-extends.
- LW: full word.
- Any other funct3: treated as word access.
REQ-011 If both MemRead_EXE and MemWrite_EXE are set, the access SHALL be treated as a store.
REQ-012 Accept requests SHALL be ignored outside IDLE; upstream holds them because stall is high.
REQ-013 In DONE, an accept condition SHALL be serviced only after returning to IDLE; back-to-back accesses take at least 3 cycles each.

Reset
REQ-014 When rst=1 at a clock edge, state SHALL become IDLE and the counter 0.
REQ-015 dm_req, dm_we, stall, ld_valid and err SHALL be 0; dm_addr, dm_wdata and ld_data SHALL be 0.
REQ-016 Reset mid-REQ SHALL abandon the access with no ld_valid or err.

Configuration
REQ-017 With LSU_MISALIGN_CHK_EN defined, a halfword access with off[0]=1 or a word access with off!=0 SHALL issue no dm_req.
- It SHALL pulse err one cycle after accept and return to IDLE.
REQ-018 Without LSU_MISALIGN_CHK_EN, misalignment SHALL NOT be checked; lane selection uses off as in REQ-009/010.

Structure
REQ-019 A shared package SHALL hold the FSM state enum and funct3 size constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
REQ-020 The lane-extension logic SHALL be a sub-module lsu_load_align (combinational: funct3, off, word -> ld_data).

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- SB, addr=0x1003, rs2=0x000000AB, dm_ready next cycle -> dm_we=1000, dm_addr=0x400, dm_wdata=0xABABABAB, stall high 2 cycles.
- LB, addr=0x0001, dm_rdata=0x0000F100 -> ld_data=0xFFFFFFF1, ld_valid pulses once; LBU same -> 0x000000F1.
- LHU, addr=0x0002, dm_rdata=0x8001_1234 -> ld_data=0x00008001.
- LW with dm_ready held 0 -> err pulses after 15 REQ cycles, state IDLE, no ld_valid.
- LSU_MISALIGN_CHK_EN defined, SW addr=0x0002 -> no dm_req, err pulse; undefined -> dm_we=1111.
- rst asserted during REQ -> next cycle dm_req=0, stall=0, no ld_valid.
